// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the fetch-side BTB branch predictor.
package branch_pred_pkg;

    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

    localparam int unsigned BP_ADDR_WIDTH = 64;
    localparam int unsigned BP_SET_COUNT  = 16;

    function automatic int unsigned index_width(input int unsigned set_count);
        return $clog2(set_count);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned set_count);
        return addr_width - 2 - $clog2(set_count);
    endfunction

    localparam int unsigned BP_TAG_WIDTH = tag_width(BP_ADDR_WIDTH, BP_SET_COUNT);

    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_WIDTH-1:0]  tag;
        logic [BP_ADDR_WIDTH-1:0] target;
        logic [1:0]               counter;
    } btb_entry_t;

    function automatic logic [1:0] counter_inc(input logic [1:0] cnt);
        return (cnt == CNT_STRONG_T) ? CNT_STRONG_T : cnt + 2'd1;
    endfunction

    function automatic logic [1:0] counter_dec(input logic [1:0] cnt);
        return (cnt == CNT_STRONG_NT) ? CNT_STRONG_NT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/plru_4way.sv
// Combinational 3-bit tree-PLRU for a 4-way set: next tree after a touch, and current victim.
module plru_4way (
    input  logic [2:0] tree_cur,
    input  logic [1:0] touch_way,
    output logic [2:0] tree_next,
    output logic [1:0] victim
);

    always_comb begin
        tree_next = tree_cur;
        // Bit0 names the LRU half; bit1/bit2 name the LRU way inside each half.
        tree_next[0] = ~touch_way[1];
        if (touch_way[1]) begin
            tree_next[2] = ~touch_way[0];
        end else begin
            tree_next[1] = ~touch_way[0];
        end
    end

    always_comb begin
        if (tree_cur[0]) begin
            victim = tree_cur[2] ? 2'd3 : 2'd2;
        end else begin
            victim = tree_cur[1] ? 2'd1 : 2'd0;
        end
    end

endmodule

// File: rtl/branch_pred_btb.sv
// Set-associative BTB with 2-bit saturating counters and per-set tree-PLRU replacement.
module branch_pred_btb
    import branch_pred_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int unsigned SET_COUNT  = BP_SET_COUNT,
    parameter int unsigned WAY_COUNT  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] pc_fetch_i,
    output logic                  branch_pred_taken_o,
    output logic [ADDR_WIDTH-1:0] pc_target_pred_o,
    output logic [1:0]            btb_way_o,
    output logic                  btb_hit_o,
    input  logic                  branch_exec_i,
    input  logic                  branch_taken_exec_i,
    input  logic [1:0]            btb_way_exec_i,
    input  logic [ADDR_WIDTH-1:0] pc_exec_i,
    input  logic [ADDR_WIDTH-1:0] pc_target_addr_i
);

    localparam int unsigned IDX_W = index_width(SET_COUNT);
    localparam int unsigned TAG_W = tag_width(ADDR_WIDTH, SET_COUNT);

    // The entry struct is sized by the package, so the geometry must agree with it.
    if (ADDR_WIDTH != BP_ADDR_WIDTH || SET_COUNT != BP_SET_COUNT || WAY_COUNT != 4) begin : g_bad_geometry
        $error("branch_pred_btb: geometry must match branch_pred_pkg");
    end

    btb_entry_t btb_q  [SET_COUNT][WAY_COUNT];
    logic [2:0] plru_q [SET_COUNT];

    logic [IDX_W-1:0] fetch_idx, exec_idx;
    logic [TAG_W-1:0] fetch_tag, exec_tag;
    logic             unused_pc_low;

    assign fetch_idx     = pc_fetch_i[IDX_W+1:2];
    assign fetch_tag     = pc_fetch_i[ADDR_WIDTH-1:IDX_W+2];
    assign exec_idx      = pc_exec_i[IDX_W+1:2];
    assign exec_tag      = pc_exec_i[ADDR_WIDTH-1:IDX_W+2];
    assign unused_pc_low = ^{pc_fetch_i[1:0], pc_exec_i[1:0]};

    logic       hit;
    logic [1:0] hit_way;
    btb_entry_t hit_entry;
    logic [1:0] fetch_victim;
    logic [2:0] unused_fetch_tree;

    plru_4way u_plru_lookup (
        .tree_cur  (plru_q[fetch_idx]),
        .touch_way (2'd0),
        .tree_next (unused_fetch_tree),
        .victim    (fetch_victim)
    );

    always_comb begin
        hit       = 1'b0;
        hit_way   = 2'd0;
        hit_entry = btb_q[fetch_idx][0];
        for (int unsigned w = 0; w < WAY_COUNT; w++) begin
            if (!hit && btb_q[fetch_idx][w].valid && btb_q[fetch_idx][w].tag == fetch_tag) begin
                hit       = 1'b1;
                hit_way   = 2'(w);
                hit_entry = btb_q[fetch_idx][w];
            end
        end
    end

    assign btb_hit_o           = hit;
    assign branch_pred_taken_o = hit & hit_entry.counter[1];
    assign pc_target_pred_o    = hit ? hit_entry.target : '0;
    assign btb_way_o           = hit ? hit_way : fetch_victim;

    btb_entry_t exec_entry;
    logic       exec_match;
    logic [2:0] exec_tree_next;
    logic [1:0] unused_exec_victim;

    assign exec_entry = btb_q[exec_idx][btb_way_exec_i];
    assign exec_match = exec_entry.valid && (exec_entry.tag == exec_tag);

    plru_4way u_plru_update (
        .tree_cur  (plru_q[exec_idx]),
        .touch_way (btb_way_exec_i),
        .tree_next (exec_tree_next),
        .victim    (unused_exec_victim)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < SET_COUNT; s++) begin
                plru_q[IDX_W'(s)] <= '0;
                for (int unsigned w = 0; w < WAY_COUNT; w++) begin
                    btb_q[IDX_W'(s)][2'(w)].valid   <= 1'b0;
                    btb_q[IDX_W'(s)][2'(w)].counter <= CNT_STRONG_NT;
                end
            end
        end else if (branch_exec_i) begin
            if (exec_match) begin
                plru_q[exec_idx] <= exec_tree_next;
                if (branch_taken_exec_i) begin
                    btb_q[exec_idx][btb_way_exec_i].counter <= counter_inc(exec_entry.counter);
                    btb_q[exec_idx][btb_way_exec_i].target  <= pc_target_addr_i;
                end else begin
                    btb_q[exec_idx][btb_way_exec_i].counter <= counter_dec(exec_entry.counter);
                end
            end else if (branch_taken_exec_i) begin
                // A stale way from fetch is simply overwritten; its old owner is evicted.
                plru_q[exec_idx]                        <= exec_tree_next;
                btb_q[exec_idx][btb_way_exec_i].valid   <= 1'b1;
                btb_q[exec_idx][btb_way_exec_i].tag     <= exec_tag;
                btb_q[exec_idx][btb_way_exec_i].target  <= pc_target_addr_i;
                btb_q[exec_idx][btb_way_exec_i].counter <= CNT_WEAK_T;
            end
        end
    end

endmodule
